// File: rtl/rr_mux_arb.sv
// Registered N-to-1 mux: manual or round-robin grant into a one-entry output register.
// Optional macro RR_MUX_ARB_HIZ_EN tri-states y while en=0; otherwise y is driven to zero.
module rr_mux_arb #(
    parameter int W = 3,
    parameter int N = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       mode,
    input  logic [$clog2(N)-1:0]       se,
    input  logic [N*W-1:0]             in_data,
    input  logic [N-1:0]               in_valid,
    output logic [N-1:0]               in_ready,
    output logic [W-1:0]               y,
    output logic                       y_valid,
    input  logic                       y_ready,
    output logic [$clog2(N)-1:0]       y_src
);
    localparam int SW = $clog2(N);

    logic [W-1:0]  data_q;
    logic          full_q;
    logic [SW-1:0] src_q;
    logic [SW-1:0] ptr_q;

    logic          load;
    logic          grant_valid;
    logic [SW-1:0] grant_idx;
    logic [SW-1:0] rr_idx;
    logic [W-1:0]  sel_data;
    logic          xfer;

    // Handshake: channel g transfers when in_valid[g] & in_ready[g]; the consumer
    // takes y when y_valid & y_ready. in_ready is one-hot or zero and may be
    // raised combinationally from y_ready, so the register refills as it drains.
    assign load = en & (~full_q | y_ready);

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        rr_idx      = '0;
        if (mode) begin
            if (int'(se) < N && in_valid[se]) begin
                grant_valid = 1'b1;
                grant_idx   = se;
            end
        end else begin
            // Walk offsets from the far end so the offset nearest ptr_q wins.
            for (int k = N - 1; k >= 0; k--) begin
                rr_idx = SW'((int'(ptr_q) + k) % N);
                if (in_valid[rr_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = rr_idx;
                end
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_idx == SW'(i)) sel_data = in_data[i*W +: W];
        end
    end

    assign xfer = load & grant_valid;

    always_comb begin
        in_ready = '0;
        if (xfer) in_ready[grant_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            full_q <= 1'b0;
            src_q  <= '0;
            ptr_q  <= '0;
        end else if (xfer) begin
            data_q <= sel_data;
            src_q  <= grant_idx;
            full_q <= 1'b1;
            if (!mode) ptr_q <= SW'((int'(grant_idx) + 1) % N);
        end else if (en & full_q & y_ready) begin
            full_q <= 1'b0;
        end
    end

    assign y_valid = en & full_q;
    assign y_src   = src_q;

`ifdef RR_MUX_ARB_HIZ_EN
    assign y = en ? data_q : {W{1'bz}};
`else
    assign y = en ? data_q : {W{1'b0}};
`endif

endmodule

// File: doc/rr_mux_arb.md
# rr_mux_arb

Parametrised, registered N-to-1 multiplexer with per-channel valid/ready handshakes. It is the next generation of the team's fixed 3-bit 4:1 enable mux. Selection is either manual (`se`) or round-robin arbitration across requesting channels. The selected word passes through a one-entry output register, and the output goes to zero or high-impedance while disabled. It sits between multiple W-bit producers and a single W-bit consumer.

## Interface
- `W`, default 3: data width per channel.
- `N`, default 4: channel count, N ≥ 2; `SW = $clog2(N)` is derived locally.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  block enable.
- `mode`  in  1  0 = round-robin, 1 = manual select via `se`.
- `se`  in  SW  manual channel select.
- `in_data`  in  N*W  flattened inputs; channel i occupies bits [i*W +: W].
- `in_valid`  in  N  per-channel request.
- `in_ready`  out  N  per-channel accept, one-hot or zero.
- `y`  out  W  output data.
- `y_valid`  out  1  output word available.
- `y_ready`  in  1  consumer accept.
- `y_src`  out  SW  channel index of the word in `y`.

## Operation
- State:
  - `data_q` [W], `full_q`, `src_q` [SW], `ptr_q` [SW] (round-robin start).
  - Reset values: `data_q`=0, `full_q`=0, `src_q`=0, `ptr_q`=0.
- `load = en & (~full_q | y_ready)`. The register may be refilled in the same cycle it drains.
- Grant, combinational:
  - Manual: grant `se` if `se < N` and `in_valid[se]`; otherwise no grant. `se ≥ N` never grants.
  - Round-robin: first i with `in_valid[i]=1`, searching ptr_q, ptr_q+1, …, N-1, 0, …, ptr_q-1 (wraps mod N).
- `in_ready[g] = load & grant valid`; every other bit is 0. A transfer on channel g occurs when `in_valid[g] & in_ready[g]`.
- On a transfer at a clock edge:
  - `data_q` ← channel g, `src_q` ← g, `full_q` ← 1.
  - Round-robin only: `ptr_q` ← (g+1) mod N.
- Manual transfers leave `ptr_q` unchanged.
- If there is no transfer and `en & full_q & y_ready`, then `full_q` ← 0.
- Outputs:
  - `y_valid = en & full_q`.
  - `y = en ? data_q : 0` (see Configuration).
  - `y_src = src_q`.
- `en`=0:
  - `in_ready` is all 0 and `y_valid` is 0.
  - `full_q`, `data_q` and `ptr_q` are held, and the word reappears when `en` returns to 1.
- A `mode` or `se` change takes effect on the next grant. It has no effect on a word already held.
- `rst` mid-operation: the held word is discarded and all state returns to its reset values on that edge.

## Timing
- Latency is 1 cycle: a transfer at edge k gives `y_valid`=1 from edge k onward.
- Sustained throughput is one word per cycle while `y_ready`=1.
- Backpressure:
  - `full_q` & ~`y_ready` ⇒ `in_ready`=0 and `data_q` is stable.
  - `y_valid` is never withdrawn without a handshake while `en`=1.
- Dependency paths:
  - `in_ready` depends combinationally on `y_ready`, `en`, `mode`, `se` and `in_valid`.
  - There is no path from `in_valid` or `in_data` to `y`.
- Simultaneous drain and refill in one cycle ⇒ `full_q` stays 1 and the new word is presented the next cycle.

## Configuration
- `RR_MUX_ARB_HIZ_EN` defined: while `en`=0, `y` is driven `{W{1'bz}}`, matching the legacy tri-state behaviour. `y_valid` and `y_src` stay driven.
- Not defined: while `en`=0, `y` is `{W{1'b0}}`. The output is fully driven, for internal buses without tri-state.

## Test plan
- Reset, round-robin: W=3, N=4, inputs a..d = 0,1,2,3, all valid, `y_ready`=1, `en`=1, `mode`=0 → `y` sequence 0,1,2,3,0 on consecutive cycles, `y_src` matching, one-hot `in_ready`.
- Manual: `mode`=1, `se`=2, `c`=3'b010 valid → `in_ready`=4'b0100, `y`=010 one cycle later. Then `se`=2 with `in_valid[2]`=0 → no transfer and `y_valid` drops after drain.
- Backpressure: hold `y_ready`=0 after the first word → `in_ready`=0, `y` stable at 000 for 5 cycles. Release → the next word is taken the same cycle.
- Fairness/wrap: only channels 3 and 1 valid, `ptr_q`=2 → grant order 3,1,3,1.
- Disable: `en`=0 with a word held → `y_valid`=0, `y`=zzz (macro defined) or 000 (undefined), `in_ready`=0. Re-enable → the same word is presented.
- Reset mid-stream: assert `rst` while `full_q`=1 → next cycle `y_valid`=0, `y_src`=0, and the round-robin restarts at channel 0.
